neuron_mac_seq: RTL and testbench
=================================

# neuron_mac_seq

Parametrised, time-multiplexed neuron for the MNIST classifier datapath. It computes one dot product per start request: NUM_INPUTS unsigned pixels times signed weights, plus a signed bias. The work is spread over NUM_LANES pipelined multiply-accumulate lanes. The result is saturated to the output format and optionally passed through ReLU. It replaces the fixed 16-lane, always-on neuron with a start/busy/done handshake, any lane count, and per-request ReLU mode. Ten instances sit under the layer controller, one per output class.

## Interface
- NUM_INPUTS, 784, number of pixel/weight pairs
- PIXEL_WIDTH, 10, unsigned pixel, integer format (10.0)
- WEIGHT_WIDTH, 19, signed weight/bias, 1 sign + 18 fraction bits
- OUTPUT_WIDTH, 26, signed result, 8 integer + 18 fraction bits
- NUM_LANES, 16, parallel multipliers; 1 <= NUM_LANES <= NUM_INPUTS
- ACC_WIDTH, 40, signed internal accumulator width; must be >= PIXEL_WIDTH+WEIGHT_WIDTH+clog2(NUM_INPUTS)+1
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- IN_PIXELS  in  NUM_INPUTS*PIXEL_WIDTH  pixel i at [i*PIXEL_WIDTH +: PIXEL_WIDTH]
- IN_WEIGHTS  in  NUM_INPUTS*WEIGHT_WIDTH  weight i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
- BIAS  in  WEIGHT_WIDTH  signed bias, same scale as a weight (18 fraction bits)
- start  in  1  request; accepted only when busy=0
- relu_en  in  1  sampled with start; 1 clamps negative results to 0
- busy  out  1  high from the accept edge until the done edge
- done  out  1  one-cycle pulse; OUT and sat are valid from this cycle onward
- OUT  out  OUTPUT_WIDTH  registered result, held until the next done
- sat  out  1  the held result was clamped to the OUTPUT_WIDTH range

## Operation
- BATCH = ceil(NUM_INPUTS/NUM_LANES).
- In step s (0..BATCH-1), lane l multiplies input index l*BATCH+s.
- Any index >= NUM_INPUTS contributes 0 (padding lanes and padding steps).
- IN_PIXELS, IN_WEIGHTS and BIAS must be held stable from the accept edge through the done edge. They are not latched.
- Product: zero-extended pixel times signed weight, giving a signed PIXEL_WIDTH+WEIGHT_WIDTH+1 bit value, sign-extended to ACC_WIDTH.
- FSM states:
  - IDLE: start accepted → RUN; step=0; lane accumulators and product registers cleared; relu_en latched.
  - RUN: one step per cycle. After step BATCH-1 is issued → DRAIN.
  - DRAIN: last products enter the accumulators → FINAL.
  - FINAL: total = sum of lane accumulators + sign-extended BIAS, computed at ACC_WIDTH.
- Saturation in FINAL:
  - total > 2^(OUTPUT_WIDTH-1)-1 → OUT = max, sat=1.
  - total < -2^(OUTPUT_WIDTH-1) → OUT = min, sat=1.
  - Otherwise OUT = total, sat=0.
- ReLU applies after saturation: if the latched relu_en=1 and the result is negative, OUT=0 and sat keeps the saturation outcome.
- In FINAL, OUT/sat are registered and done=1; then → IDLE.
- A start while busy=1 is ignored: no queuing, no error.
- A start in the done cycle is accepted, because busy=0 in that cycle. Back-to-back requests therefore have no bubble.
- rst in any state → IDLE.
  - OUT=0, sat=0, done=0, busy=0; all accumulators and product registers cleared.
  - Any partial result is discarded.
  - rst has priority over a simultaneous start.

## Timing
- Edge E0 is the edge at which start is sampled in IDLE; busy=1 after E0.
- Products for step s are registered at E(s+1).
- Accumulation for step s happens at E(s+2).
- OUT, sat and done=1 are registered at E(BATCH+2); busy=0 after that edge.
- Latency: BATCH+2 clock edges from accept to done. Default configuration: 51.
- Throughput: one result per BATCH+2 cycles.
- done is high for exactly one cycle per accepted request.
- After reset, outputs are 0 until the first done.

## Test plan
- **Scaling check.** Defaults; all pixels=1, all weights=19'h00001, BIAS=0, relu_en=0, start pulse → done exactly 51 cycles after the accept edge; OUT=26'd784, sat=0, busy high for 51 cycles.
- **Negative result and ReLU.** Pixel[0]=1, weight[0]=19'h40000 (-1.0), all others 0, BIAS=19'h00100:
  - relu_en=0 → OUT=26'h3FC0100, sat=0.
  - Repeat with relu_en=1 → OUT=0, sat=0.
- **Positive saturation.** All pixels=1023, all weights=19'h3FFFF → OUT=26'h1FFFFFF, sat=1.
- **Negative saturation.** Same pixels, all weights=19'h40000 → OUT=26'h2000000, sat=1.
- **Ragged partition.** NUM_INPUTS=10, NUM_LANES=4 (BATCH=3, two padding slots); pixel i=i+1, weight i=19'h00001 → OUT=55, done 5 cycles after accept. Compare against a behavioural model using random vectors (≥200 runs).
- **Handshake.**
  - start held high throughout a run → only one accept per run.
  - A start in the done cycle → the second request is accepted and its done comes 51 cycles later.
  - start pulses mid-run → ignored; the in-flight result is unchanged.
- **Reset.**
  - rst asserted at step 20 → the next cycle shows OUT=0, sat=0, busy=0, done=0.
  - A new start then produces the correct result with no residue from the aborted run.
  - rst and start in the same cycle → the request is not accepted.

Source files
------------

// File: rtl/neuron_mac_seq.sv
// Time-multiplexed neuron: NUM_INPUTS-term dot product of unsigned pixels and signed weights
// over NUM_LANES pipelined MAC lanes, plus bias, saturation and optional ReLU.
module neuron_mac_seq #(
  parameter int NUM_INPUTS   = 784,
  parameter int PIXEL_WIDTH  = 10,
  parameter int WEIGHT_WIDTH = 19,
  parameter int OUTPUT_WIDTH = 26,
  parameter int NUM_LANES    = 16,
  parameter int ACC_WIDTH    = 40
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_INPUTS*PIXEL_WIDTH-1:0]    IN_PIXELS,
  input  logic [NUM_INPUTS*WEIGHT_WIDTH-1:0]   IN_WEIGHTS,
  input  logic [WEIGHT_WIDTH-1:0]              BIAS,
  input  logic                                 start,
  input  logic                                 relu_en,
  output logic                                 busy,
  output logic                                 done,
  output logic [OUTPUT_WIDTH-1:0]              OUT,
  output logic                                 sat
);

  localparam int BATCH  = (NUM_INPUTS + NUM_LANES - 1) / NUM_LANES;
  localparam int STEP_W = $clog2(BATCH + 1);
  localparam int PROD_W = PIXEL_WIDTH + WEIGHT_WIDTH + 1;
  localparam int PIX_IW = $clog2(NUM_INPUTS * PIXEL_WIDTH);
  localparam int WGT_IW = $clog2(NUM_INPUTS * WEIGHT_WIDTH);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(BATCH - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    {{(ACC_WIDTH-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
    {{(ACC_WIDTH-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINAL} state_t;

  state_t                        state, state_next;
  logic [STEP_W-1:0]             step;
  logic                          relu_q;
  logic                          vld_p1;
  logic signed [ACC_WIDTH-1:0]   prod_c  [NUM_LANES];
  logic signed [ACC_WIDTH-1:0]   prod_p1 [NUM_LANES];
  logic signed [ACC_WIDTH-1:0]   acc_p2  [NUM_LANES];
  logic signed [ACC_WIDTH-1:0]   total;
  logic [OUTPUT_WIDTH:0]         sat_res;

  // Returns {clamped, value}
  function automatic logic [OUTPUT_WIDTH:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
    if (v > OUT_MAX) return {1'b1, OUT_MAX[OUTPUT_WIDTH-1:0]};
    if (v < OUT_MIN) return {1'b1, OUT_MIN[OUTPUT_WIDTH-1:0]};
    return {1'b0, v[OUTPUT_WIDTH-1:0]};
  endfunction

  function automatic logic [OUTPUT_WIDTH-1:0] relu(input logic [OUTPUT_WIDTH-1:0] v,
                                                    input logic en);
    if (en && v[OUTPUT_WIDTH-1]) return '0;
    return v;
  endfunction

  // Stage 0: lane l fetches input l*BATCH+step; out-of-range slots contribute zero
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    int                          idx;
    logic [PIXEL_WIDTH-1:0]      pix;
    logic signed [WEIGHT_WIDTH-1:0] wgt;
    logic signed [PROD_W-1:0]    pix_x, wgt_x, prod;

    always_comb begin
      pix = '0;
      wgt = '0;
      idx = l * BATCH + int'(step);
      if (idx < NUM_INPUTS) begin
        pix = IN_PIXELS[PIX_IW'(idx * PIXEL_WIDTH) +: PIXEL_WIDTH];
        wgt = IN_WEIGHTS[WGT_IW'(idx * WEIGHT_WIDTH) +: WEIGHT_WIDTH];
      end
      pix_x = PROD_W'({1'b0, pix});
      wgt_x = PROD_W'(wgt);
      prod  = pix_x * wgt_x;
    end

    assign prod_c[l] = ACC_WIDTH'(prod);
  end

  always_comb begin
    total = ACC_WIDTH'(signed'(BIAS));
    for (int l = 0; l < NUM_LANES; l++) total = total + acc_p2[l];
    sat_res = saturate(total);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (step == LAST_STEP) state_next = DRAIN;
      DRAIN:   state_next = FINAL;
      FINAL:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      step   <= '0;
      relu_q <= 1'b0;
      vld_p1 <= 1'b0;
      done   <= 1'b0;
      OUT    <= '0;
      sat    <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
        prod_p1[l] <= '0;
        acc_p2[l]  <= '0;
      end
    end else begin
      done <= (state == FINAL);
      case (state)
        IDLE: begin
          if (start) begin
            step   <= '0;
            relu_q <= relu_en;
            vld_p1 <= 1'b0;
            for (int l = 0; l < NUM_LANES; l++) begin
              prod_p1[l] <= '0;
              acc_p2[l]  <= '0;
            end
          end
        end
        // Stage 1 registers this step's products; stage 2 folds the previous step in
        RUN: begin
          step   <= step + 1'b1;
          vld_p1 <= 1'b1;
          for (int l = 0; l < NUM_LANES; l++) begin
            prod_p1[l] <= prod_c[l];
            if (vld_p1) acc_p2[l] <= acc_p2[l] + prod_p1[l];
          end
        end
        DRAIN: begin
          vld_p1 <= 1'b0;
          for (int l = 0; l < NUM_LANES; l++) begin
            if (vld_p1) acc_p2[l] <= acc_p2[l] + prod_p1[l];
          end
        end
        // Stage 3: lane sum + bias, saturate, then ReLU
        FINAL: begin
          OUT <= relu(sat_res[OUTPUT_WIDTH-1:0], relu_q);
          sat <= sat_res[OUTPUT_WIDTH];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Scoreboard bench: a default 784x16 neuron and a ragged 10x4 neuron share clock and reset.
module tb_neuron_mac_seq;

  localparam int NB = 784, NS = 10, PW = 10, WW = 19, OW = 26;
  localparam int LAT_B = 51, LAT_S = 5;

  typedef struct packed {
    logic [OW-1:0] out;
    logic          sat;
    int            cyc;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic start_b = 1'b0, relu_b = 1'b0, busy_b, done_b, sat_b;
  logic start_s = 1'b0, relu_s = 1'b0, busy_s, done_s, sat_s;
  logic [OW-1:0] out_b, out_s;
  logic [NB*PW-1:0] pix_b = '0;
  logic [NB*WW-1:0] wgt_b = '0;
  logic [NS*PW-1:0] pix_s = '0;
  logic [NS*WW-1:0] wgt_s = '0;
  logic [WW-1:0] bias_b = '0, bias_s = '0;

  int cyc = 0, errors = 0, checks = 0;
  exp_t q_b[$], q_s[$];
  exp_t eb, es;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  neuron_mac_seq dut_b (
    .clk(clk), .rst(rst), .IN_PIXELS(pix_b), .IN_WEIGHTS(wgt_b), .BIAS(bias_b),
    .start(start_b), .relu_en(relu_b), .busy(busy_b), .done(done_b), .OUT(out_b), .sat(sat_b));

  neuron_mac_seq #(.NUM_INPUTS(NS), .NUM_LANES(4)) dut_s (
    .clk(clk), .rst(rst), .IN_PIXELS(pix_s), .IN_WEIGHTS(wgt_s), .BIAS(bias_s),
    .start(start_s), .relu_en(relu_s), .busy(busy_s), .done(done_s), .OUT(out_s), .sat(sat_s));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: pop and compare whenever a done pulse appears
  always @(negedge clk) begin
    if (done_b) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL big_unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        eb = q_b.pop_front();
        chk("big_out", 32'(out_b), 32'(eb.out));
        chk("big_sat", 32'(sat_b), 32'(eb.sat));
        chk("big_latency", 32'(cyc), 32'(eb.cyc));
        chk("big_busy_at_done", 32'(busy_b), 32'd0);
      end
    end
    if (done_s) begin
      checks++;
      if (q_s.size() == 0) begin
        errors++;
        $display("FAIL small_unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        es = q_s.pop_front();
        chk("small_out", 32'(out_s), 32'(es.out));
        chk("small_sat", 32'(sat_s), 32'(es.sat));
        chk("small_latency", 32'(cyc), 32'(es.cyc));
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (q_b.size() == 0 && q_s.size() == 0 && !busy_b && !busy_s) return;
    end
    errors++; checks++;
    $display("FAIL wait_idle_timeout: got pending=%0d/%0d expected 0/0", q_b.size(), q_s.size());
    q_b.delete(); q_s.delete();
  endtask

  task automatic set_big(input logic [PW-1:0] p, input logic [WW-1:0] w, input logic [WW-1:0] b);
    for (int i = 0; i < NB; i++) begin
      pix_b[i*PW +: PW] = p;
      wgt_b[i*WW +: WW] = w;
    end
    bias_b = b;
  endtask

  task automatic go_big(input logic relu, input logic [OW-1:0] eo, input logic esat, input bit push);
    relu_b = relu; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    if (push) q_b.push_back('{eo, esat, cyc + LAT_B});
  endtask

  task automatic go_small(input logic relu, input logic [OW-1:0] eo, input logic esat);
    relu_s = relu; start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    q_s.push_back('{eo, esat, cyc + LAT_S});
  endtask

  // Reference: plain sum over all inputs, then clamp, then ReLU
  task automatic model_small(input logic relu, output logic [OW-1:0] eo, output logic esat);
    longint sum, p, w;
    logic [WW-1:0] wr;
    sum = longint'($signed(bias_s));
    for (int i = 0; i < NS; i++) begin
      p  = longint'(pix_s[i*PW +: PW]);
      wr = wgt_s[i*WW +: WW];
      w  = longint'($signed(wr));
      sum += p * w;
    end
    esat = 1'b0;
    if (sum > 64'sd33554431) begin eo = 26'h1FFFFFF; esat = 1'b1; end
    else if (sum < -64'sd33554432) begin eo = 26'h2000000; esat = 1'b1; end
    else eo = sum[OW-1:0];
    if (relu && eo[OW-1]) eo = '0;
  endtask

  initial begin
    int n;
    bit seen;
    logic [OW-1:0] eo;
    logic esat, r;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out", 32'(out_b), 32'd0);
    chk("rst_sat", 32'(sat_b), 32'd0);
    chk("rst_busy", 32'(busy_b), 32'd0);
    chk("rst_done", 32'(done_b), 32'd0);

    // Scaling: 784 * 1 * 2^-18, busy for 51 cycles
    set_big(10'd1, 19'h00001, 19'h0);
    go_big(1'b0, 26'd784, 1'b0, 1'b1);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy_b) break;
      n++;
    end
    chk("busy_cycles", 32'(n), 32'd51);
    wait_idle();

    // Single negative term plus bias, with and without ReLU
    set_big(10'd0, 19'h0, 19'h00100);
    pix_b[PW-1:0] = 10'd1;
    wgt_b[WW-1:0] = 19'h40000;
    go_big(1'b0, 26'h3FC0100, 1'b0, 1'b1);
    wait_idle();
    go_big(1'b1, 26'h0, 1'b0, 1'b1);
    wait_idle();

    // Saturation in both directions
    set_big(10'd1023, 19'h3FFFF, 19'h0);
    go_big(1'b0, 26'h1FFFFFF, 1'b1, 1'b1);
    wait_idle();
    set_big(10'd1023, 19'h40000, 19'h0);
    go_big(1'b0, 26'h2000000, 1'b1, 1'b1);
    wait_idle();
    go_big(1'b1, 26'h0, 1'b1, 1'b1);
    wait_idle();

    // start held high: one accept per run, then a back-to-back accept in the done cycle
    set_big(10'd1, 19'h00001, 19'h0);
    relu_b = 1'b0; start_b = 1'b1;
    @(posedge clk); #1;
    q_b.push_back('{26'd784, 1'b0, cyc + LAT_B});
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done_b) begin seen = 1'b1; break; end
    end
    chk("held_start_done_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    q_b.push_back('{26'd784, 1'b0, cyc + LAT_B});
    start_b = 1'b0;
    wait_idle();

    // Mid-run start pulses (with relu_en=1) must be ignored
    set_big(10'd0, 19'h0, 19'h00100);
    pix_b[PW-1:0] = 10'd1;
    wgt_b[WW-1:0] = 19'h40000;
    go_big(1'b0, 26'h3FC0100, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #1 start_b = 1'b1; relu_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    repeat (20) @(posedge clk);
    #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0; relu_b = 1'b0;
    wait_idle();

    // Reset mid-run discards the partial result
    set_big(10'd1, 19'h00001, 19'h0);
    go_big(1'b0, 26'd0, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out", 32'(out_b), 32'd0);
    chk("midrst_sat", 32'(sat_b), 32'd0);
    chk("midrst_busy", 32'(busy_b), 32'd0);
    chk("midrst_done", 32'(done_b), 32'd0);
    go_big(1'b0, 26'd784, 1'b0, 1'b1);
    wait_idle();

    // Reset wins over a simultaneous start
    rst = 1'b1; start_b = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start_b = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", 32'(busy_b), 32'd0);
    repeat (60) @(negedge clk);
    chk("rst_start_out", 32'(out_b), 32'd0);

    // Ragged partition: 1+2+...+10
    for (int i = 0; i < NS; i++) begin
      pix_s[i*PW +: PW] = PW'(i + 1);
      wgt_s[i*WW +: WW] = 19'h00001;
    end
    bias_s = '0;
    go_small(1'b0, 26'd55, 1'b0);
    wait_idle();

    // Ragged partition against the reference model
    for (int t = 0; t < 200; t++) begin
      for (int i = 0; i < NS; i++) begin
        pix_s[i*PW +: PW] = (t % 2 == 0) ? PW'($urandom_range(0, 15)) : PW'($urandom_range(0, 1023));
        wgt_s[i*WW +: WW] = WW'($urandom);
      end
      bias_s = WW'($urandom);
      r = 1'($urandom_range(0, 1));
      model_small(r, eo, esat);
      go_small(r, eo, esat);
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
